boot_loader: RTL and testbench

Boot sequencer between the BIOS ROM, the hard-disk (HD) port and the instruction memory (IM). After reset the CPU fetches from BIOS. When the BIOS signals completion, this block stalls the CPU, reads a length header and then a program image from HD, writes the image into IM starting at address 0, and switches instruction fetch from BIOS to IM. Header errors park the CPU on hold with an error flag.

---
 rtl/galetron_pkg.sv | 22 ++
 rtl/boot_loader_if.sv | 38 +++
 rtl/boot_loader.sv | 144 ++++++++++++++
 tb/tb_boot_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/galetron_pkg.sv
// Shared definitions for the galetron CPU, BIOS ROM, memories and boot loader.
//   DW     : data word width
//   IM_AW  : instruction memory address width
//   HD_AW  : hard-disk address width
//   boot_state_e : boot sequencer states
package galetron_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned IM_AW = 10;
  localparam int unsigned HD_AW = 10;

  typedef enum logic [2:0] {
    ST_BIOS,
    ST_HDR_REQ,
    ST_CHECK,
    ST_DATA_REQ,
    ST_WRITE,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: HD read handshake plus IM write port.
//   hd_req  / hd_addr : read request (level) and address, loader -> HD
//   hd_ack  / hd_data : acknowledge and read data, HD -> loader
//   im_we / im_addr / im_data : one-cycle write strobe and payload, loader -> IM
// Modports: master = boot loader side, slave = HD/IM side.
interface boot_loader_if
  import galetron_pkg::*;
();

  logic             hd_req;
  logic [HD_AW-1:0] hd_addr;
  logic             hd_ack;
  logic [DW-1:0]    hd_data;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [DW-1:0]    im_data;

  modport master (
    output hd_req,
    output hd_addr,
    input  hd_ack,
    input  hd_data,
    output im_we,
    output im_addr,
    output im_data
  );

  modport slave (
    input  hd_req,
    input  hd_addr,
    output hd_ack,
    output hd_data,
    input  im_we,
    input  im_addr,
    input  im_data
  );

endinterface

// File: rtl/boot_loader.sv
// Boot sequencer between BIOS ROM, hard disk and instruction memory.
// After BIOS completion (boot_start) the CPU is held, a length header L is
// read from HD_BASE, L words are copied from HD_BASE+1.. into IM[0..L-1],
// then fetch switches to IM. A bad header (L==0 or L>IM_DEPTH) parks the
// CPU on hold with a sticky error flag.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   boot_start        : BIOS-complete pulse, only honoured in BIOS state
//   bus (master)      : HD read handshake and IM write port
//   cpu_hold          : stall CPU pipeline
//   fetch_sel         : 0 = fetch from BIOS, 1 = fetch from IM
//   done              : program loaded and running from IM
//   error             : invalid header, sticky until reset
// All outputs are registers; nothing from an input reaches an output
// combinationally.
module boot_loader
  import galetron_pkg::*;
#(
  parameter int unsigned HD_BASE  = 0,
  parameter int unsigned IM_DEPTH = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          boot_start,
  boot_loader_if.master bus,
  output logic          cpu_hold,
  output logic          fetch_sel,
  output logic          done,
  output logic          error
);

  // One extra bit so a full-depth image (L == IM_DEPTH) does not wrap k.
  localparam int unsigned KW = IM_AW + 1;

  boot_state_e      state_q;
  logic [KW-1:0]    k_q;
  logic [DW-1:0]    len_q;
  logic             hd_req_q;
  logic [HD_AW-1:0] hd_addr_q;
  logic             im_we_q;
  logic [IM_AW-1:0] im_addr_q;
  logic [DW-1:0]    im_data_q;
  logic             cpu_hold_q;
  logic             fetch_sel_q;
  logic             done_q;
  logic             error_q;

  logic len_bad;
  logic last_word;

  // HD address of image word k; wraps modulo 2^HD_AW by truncation.
  function automatic logic [HD_AW-1:0] img_addr(input logic [KW-1:0] k);
    return HD_AW'(HD_BASE + 32'd1 + 32'(k));
  endfunction

  // Full-width length compare: upper header bits must not be ignored.
  assign len_bad   = (len_q == '0) || (len_q > DW'(IM_DEPTH));
  assign last_word = (DW'(k_q) == (len_q - DW'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_BIOS;
      k_q         <= '0;
      len_q       <= '0;
      hd_req_q    <= 1'b0;
      hd_addr_q   <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_data_q   <= '0;
      cpu_hold_q  <= 1'b0;
      fetch_sel_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        ST_BIOS: begin
          if (boot_start) begin
            state_q    <= ST_HDR_REQ;
            hd_req_q   <= 1'b1;
            hd_addr_q  <= HD_AW'(HD_BASE);
            cpu_hold_q <= 1'b1;
          end
        end
        ST_HDR_REQ: begin
          if (bus.hd_ack) begin
            len_q    <= bus.hd_data;
            hd_req_q <= 1'b0;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (len_bad) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else begin
            k_q       <= '0;
            hd_req_q  <= 1'b1;
            hd_addr_q <= img_addr('0);
            state_q   <= ST_DATA_REQ;
          end
        end
        ST_DATA_REQ: begin
          // The write strobe and payload are registered here so they appear
          // exactly during the WRITE state.
          if (bus.hd_ack) begin
            hd_req_q  <= 1'b0;
            im_we_q   <= 1'b1;
            im_addr_q <= k_q[IM_AW-1:0];
            im_data_q <= bus.hd_data;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last_word) begin
            state_q     <= ST_RUN;
            cpu_hold_q  <= 1'b0;
            fetch_sel_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            k_q       <= k_q + KW'(1);
            hd_req_q  <= 1'b1;
            hd_addr_q <= img_addr(k_q + KW'(1));
            state_q   <= ST_DATA_REQ;
          end
        end
        ST_RUN:   state_q <= ST_RUN;
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_BIOS;
      endcase
    end
  end

  assign bus.hd_req  = hd_req_q;
  assign bus.hd_addr = hd_addr_q;
  assign bus.im_we   = im_we_q;
  assign bus.im_addr = im_addr_q;
  assign bus.im_data = im_data_q;
  assign cpu_hold    = cpu_hold_q;
  assign fetch_sel   = fetch_sel_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader: HD responder with optional
// wait states, IM write monitor, and hand-computed expectations.
module tb_boot_loader;
  import galetron_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic boot_start;
  logic cpu_hold, fetch_sel, done, error;

  boot_loader_if bus();

  boot_loader #(.HD_BASE(0), .IM_DEPTH(1024)) dut (
    .clock      (clock),
    .reset      (reset),
    .boot_start (boot_start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .fetch_sel  (fetch_sel),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  logic [31:0] hd_mem [0:1023];
  logic [31:0] im_mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int last_im_addr = -1;
  int last_rd_addr = -1;
  int addr_bad = 0;
  bit tie = 1'b0;
  bit busy = 1'b0;
  int wl = 0;
  logic [HD_AW-1:0] a0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // HD responder and IM monitor, both acting on the falling edge.
  initial begin
    bus.hd_ack  = 1'b0;
    bus.hd_data = '0;
    forever begin
      @(negedge clock);
      if (bus.im_we === 1'b1) begin
        im_mem[bus.im_addr] = bus.im_data;
        wr_cnt++;
        last_im_addr = int'(bus.im_addr);
      end
      if (tie) begin
        bus.hd_ack  = 1'b1;
        bus.hd_data = hd_mem[bus.hd_addr];
        if (bus.hd_req === 1'b1) last_rd_addr = int'(bus.hd_addr);
      end else if (bus.hd_req === 1'b1 && bus.hd_ack === 1'b0) begin
        if (!busy) begin
          busy = 1'b1;
          wl   = $urandom_range(1, 3);
          a0   = bus.hd_addr;
        end else if (bus.hd_addr !== a0) begin
          addr_bad++;
        end
        if (wl == 0) begin
          bus.hd_ack   = 1'b1;
          bus.hd_data  = hd_mem[bus.hd_addr];
          last_rd_addr = int'(bus.hd_addr);
          busy         = 1'b0;
        end else begin
          wl--;
        end
      end else begin
        bus.hd_ack = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    reset = 1'b1;
    boot_start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    busy = 1'b0;
    addr_bad = 0;
  endtask

  task automatic clear_im();
    for (int i = 0; i < 1024; i++) im_mem[i] = 32'hDEAD_BEEF;
    wr_cnt = 0;
    last_im_addr = -1;
    last_rd_addr = -1;
  endtask

  // Pulses boot_start and counts edges (the sampling edge is 1) until RUN or
  // ERROR is visible; cpu_hold must be high in every cycle before that.
  task automatic run_boot(input int budget, output int n, output int hbad);
    n = 0;
    hbad = 0;
    boot_start = 1'b1;
    while (n < budget) begin
      @(posedge clock);
      n++;
      #1 boot_start = 1'b0;
      @(negedge clock);
      if (fetch_sel === 1'b1 || error === 1'b1) break;
      if (cpu_hold !== 1'b1) hbad++;
    end
    check("boot_ended", {31'd0, (fetch_sel | error)}, 32'd1);
  endtask

  int n, hbad, mm, bad;

  initial begin
    for (int i = 0; i < 1024; i++) hd_mem[i] = 32'h0;
    clear_im();
    apply_reset();

    // Reset values
    check("rst_hd_req",   {31'd0, bus.hd_req}, 32'd0);
    check("rst_hd_addr",  32'(bus.hd_addr), 32'd0);
    check("rst_im_we",    {31'd0, bus.im_we}, 32'd0);
    check("rst_im_addr",  32'(bus.im_addr), 32'd0);
    check("rst_im_data",  bus.im_data, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_fetch",    {31'd0, fetch_sel}, 32'd0);
    check("rst_done",     {31'd0, done}, 32'd0);
    check("rst_error",    {31'd0, error}, 32'd0);

    // Idle in BIOS for 20 cycles
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (fetch_sel !== 1'b0 || cpu_hold !== 1'b0 || bus.hd_req !== 1'b0) bad++;
    end
    check("idle_bios", bad, 0);

    // L=3, ack tied high (also high while hd_req=0)
    hd_mem[0] = 32'd3; hd_mem[1] = 32'hA; hd_mem[2] = 32'hB; hd_mem[3] = 32'hC;
    clear_im();
    tie = 1'b1;
    run_boot(100, n, hbad);
    check("L3_run_cycle", n, 9);
    check("L3_hold_load", hbad, 0);
    check("L3_im0", im_mem[0], 32'hA);
    check("L3_im1", im_mem[1], 32'hB);
    check("L3_im2", im_mem[2], 32'hC);
    check("L3_writes", wr_cnt, 3);
    check("L3_done", {31'd0, done}, 32'd1);
    check("L3_fetch", {31'd0, fetch_sel}, 32'd1);
    check("L3_hold", {31'd0, cpu_hold}, 32'd0);
    check("L3_error", {31'd0, error}, 32'd0);

    // Same image with random wait states
    tie = 1'b0;
    apply_reset();
    clear_im();
    run_boot(200, n, hbad);
    check("W3_addr_stable", addr_bad, 0);
    check("W3_hold_load", hbad, 0);
    check("W3_im0", im_mem[0], 32'hA);
    check("W3_im1", im_mem[1], 32'hB);
    check("W3_im2", im_mem[2], 32'hC);
    check("W3_writes", wr_cnt, 3);
    check("W3_done", {31'd0, done}, 32'd1);

    // L=0 -> ERROR at cycle 3
    tie = 1'b1;
    apply_reset();
    clear_im();
    hd_mem[0] = 32'd0;
    run_boot(100, n, hbad);
    check("L0_err_cycle", n, 3);
    repeat (5) @(negedge clock);
    check("L0_error", {31'd0, error}, 32'd1);
    check("L0_hold", {31'd0, cpu_hold}, 32'd1);
    check("L0_fetch", {31'd0, fetch_sel}, 32'd0);
    check("L0_done", {31'd0, done}, 32'd0);
    check("L0_writes", wr_cnt, 0);

    // L=1025 -> ERROR
    apply_reset();
    clear_im();
    hd_mem[0] = 32'd1025;
    run_boot(100, n, hbad);
    repeat (5) @(negedge clock);
    check("L1025_error", {31'd0, error}, 32'd1);
    check("L1025_hold", {31'd0, cpu_hold}, 32'd1);
    check("L1025_writes", wr_cnt, 0);

    // Large header with upper bits set must still be rejected
    apply_reset();
    clear_im();
    hd_mem[0] = 32'h0001_0003;
    run_boot(100, n, hbad);
    check("Lbig_error", {31'd0, error}, 32'd1);
    check("Lbig_writes", wr_cnt, 0);

    // L=1024: last word comes from HD address 1024 mod 1024 = 0 (the header)
    apply_reset();
    clear_im();
    hd_mem[0] = 32'd1024;
    for (int i = 1; i < 1024; i++) hd_mem[i] = 32'h5000_0000 + 32'(i);
    run_boot(3000, n, hbad);
    check("L1024_run_cycle", n, 2051);
    check("L1024_writes", wr_cnt, 1024);
    check("L1024_last_im", last_im_addr, 1023);
    check("L1024_last_hd", last_rd_addr, 0);
    check("L1024_im1023", im_mem[1023], 32'd1024);
    mm = 0;
    for (int j = 0; j < 1023; j++) if (im_mem[j] !== 32'h5000_0000 + 32'(j + 1)) mm++;
    check("L1024_image", mm, 0);
    check("L1024_done", {31'd0, done}, 32'd1);

    // L=10, reset during word 5, then reload with new data
    apply_reset();
    clear_im();
    hd_mem[0] = 32'd10;
    for (int i = 1; i <= 10; i++) hd_mem[i] = 32'h100 + 32'(i);
    boot_start = 1'b1;
    @(posedge clock);
    #1 boot_start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      #1;
      n++;
      if (wr_cnt >= 5) break;
    end
    check("R10_five_written", wr_cnt, 5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("R10_hd_req", {31'd0, bus.hd_req}, 32'd0);
    check("R10_im_we", {31'd0, bus.im_we}, 32'd0);
    check("R10_fetch", {31'd0, fetch_sel}, 32'd0);
    check("R10_hold", {31'd0, cpu_hold}, 32'd0);
    reset = 1'b0;
    busy = 1'b0;
    clear_im();
    for (int i = 1; i <= 10; i++) hd_mem[i] = 32'h200 + 32'(i);
    run_boot(100, n, hbad);
    check("R10_run_cycle", n, 23);
    check("R10_writes", wr_cnt, 10);
    mm = 0;
    for (int j = 0; j < 10; j++) if (im_mem[j] !== 32'h200 + 32'(j + 1)) mm++;
    check("R10_image", mm, 0);
    check("R10_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
